// File: rtl/crono_pkg.sv
// rtl/crono_pkg.sv - shared types and digit limits for the stopwatch controller
package crono_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  localparam logic [3:0] SEC_U_MAX = 4'd9;
  localparam logic [2:0] SEC_T_MAX = 3'd5;
  localparam logic [3:0] MIN_U_MAX = 4'd9;

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - button synchronizer with single-cycle rising-edge event
module btn_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the raw button through the synchronizer and keep the last settled level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q[0] <= btn;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Held buttons produce one event: only the low-to-high step of the settled level counts.
  assign pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/crono_ctrl.sv
// rtl/crono_ctrl.sv - run/pause/lap controller driving the stopwatch digit chain
module crono_ctrl
  import crono_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int TICK_HZ     = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       BTN_SS,
  input  logic       BTN_CLR,
  input  logic       BTN_LAP,
  output logic       UNI_INC,
  output logic       DEZ_INC,
  output logic       MIN_INC,
  output logic       DIG_CLR,
  output logic       DISP_HOLD,
  output logic       RUNNING,
  output logic       OVF,
  output logic [3:0] SEC_U,
  output logic [2:0] SEC_T,
  output logic [3:0] MIN_U
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic ev_ss, ev_clr, ev_lap;

  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss (
    .clk(CLK), .rst_n(RST_N), .btn(BTN_SS), .pulse(ev_ss)
  );
  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clr (
    .clk(CLK), .rst_n(RST_N), .btn(BTN_CLR), .pulse(ev_clr)
  );
  btn_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lap (
    .clk(CLK), .rst_n(RST_N), .btn(BTN_LAP), .pulse(ev_lap)
  );

  state_t        state, state_nxt;
  logic          hold_q, hold_nxt;
  logic [PW-1:0] presc_q, presc_nxt;
  logic [3:0]    sec_u_q, sec_u_nxt;
  logic [2:0]    sec_t_q, sec_t_nxt;
  logic [3:0]    min_u_q, min_u_nxt;
  logic          uni_q, uni_nxt;
  logic          dez_q, dez_nxt;
  logic          min_q, min_nxt;
  logic          ovf_q, ovf_nxt;
  logic          clr_q, clr_nxt;
  logic          counting;
  logic          tick;

  // Register FSM state, prescaler, shadow BCD count and all output strobes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      hold_q  <= 1'b0;
      presc_q <= '0;
      sec_u_q <= '0;
      sec_t_q <= '0;
      min_u_q <= '0;
      uni_q   <= 1'b0;
      dez_q   <= 1'b0;
      min_q   <= 1'b0;
      ovf_q   <= 1'b0;
      clr_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      hold_q  <= hold_nxt;
      presc_q <= presc_nxt;
      sec_u_q <= sec_u_nxt;
      sec_t_q <= sec_t_nxt;
      min_u_q <= min_u_nxt;
      uni_q   <= uni_nxt;
      dez_q   <= dez_nxt;
      min_q   <= min_nxt;
      ovf_q   <= ovf_nxt;
      clr_q   <= clr_nxt;
    end
  end

  // Next state: prescaler and carry chain first, then button events by state priority.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_q;
    presc_nxt = presc_q;
    sec_u_nxt = sec_u_q;
    sec_t_nxt = sec_t_q;
    min_u_nxt = min_u_q;
    uni_nxt   = 1'b0;
    dez_nxt   = 1'b0;
    min_nxt   = 1'b0;
    ovf_nxt   = 1'b0;
    clr_nxt   = 1'b0;

    counting = (state == ST_RUN) || (state == ST_LAP);
    tick     = counting && (presc_q == PRESC_LAST);

    // The prescaler only moves while counting, so a pause keeps the partial second.
    if (counting) begin
      if (tick) presc_nxt = '0;
      else      presc_nxt = presc_q + PW'(1);
    end

    // A tick in the same cycle as a stop still finishes: the strobes go out regardless of the event.
    if (tick) begin
      uni_nxt = 1'b1;
      if (sec_u_q == SEC_U_MAX) begin
        sec_u_nxt = '0;
        dez_nxt   = 1'b1;
        if (sec_t_q == SEC_T_MAX) begin
          sec_t_nxt = '0;
          min_nxt   = 1'b1;
          if (min_u_q == MIN_U_MAX) begin
            min_u_nxt = '0;
            ovf_nxt   = 1'b1;
          end else begin
            min_u_nxt = min_u_q + 4'd1;
          end
        end else begin
          sec_t_nxt = sec_t_q + 3'd1;
        end
      end else begin
        sec_u_nxt = sec_u_q + 4'd1;
      end
    end

    case (state)
      ST_IDLE: begin
        if (ev_clr) begin
          clr_nxt   = 1'b1;
          sec_u_nxt = '0;
          sec_t_nxt = '0;
          min_u_nxt = '0;
        end else if (ev_ss) begin
          state_nxt = ST_RUN;
          presc_nxt = '0;
        end
      end
      ST_RUN: begin
        if (ev_ss) begin
          state_nxt = ST_PAUSE;
        end else if (ev_lap) begin
          state_nxt = ST_LAP;
          hold_nxt  = 1'b1;
        end
      end
      ST_LAP: begin
        // Stopping from lap view leaves the frozen lap on the display.
        if (ev_ss) begin
          state_nxt = ST_PAUSE;
        end else if (ev_lap) begin
          state_nxt = ST_RUN;
          hold_nxt  = 1'b0;
        end
      end
      ST_PAUSE: begin
        if (ev_clr) begin
          state_nxt = ST_IDLE;
          clr_nxt   = 1'b1;
          hold_nxt  = 1'b0;
          presc_nxt = '0;
          sec_u_nxt = '0;
          sec_t_nxt = '0;
          min_u_nxt = '0;
        end else if (ev_ss) begin
          state_nxt = ST_RUN;
          hold_nxt  = 1'b0;
        end else if (ev_lap) begin
          hold_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign UNI_INC   = uni_q;
  assign DEZ_INC   = dez_q;
  assign MIN_INC   = min_q;
  assign OVF       = ovf_q;
  assign DIG_CLR   = clr_q;
  assign DISP_HOLD = hold_q;
  assign RUNNING   = (state == ST_RUN) || (state == ST_LAP);
  assign SEC_U     = sec_u_q;
  assign SEC_T     = sec_t_q;
  assign MIN_U     = min_u_q;

endmodule

// File: tb/tb_crono_ctrl.sv
// tb/tb_crono_ctrl.sv - self-checking bench for crono_ctrl
module tb_crono_ctrl;

  localparam int DIV = 10;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       BTN_SS = 1'b0, BTN_CLR = 1'b0, BTN_LAP = 1'b0;
  logic       UNI_INC, DEZ_INC, MIN_INC, DIG_CLR, DISP_HOLD, RUNNING, OVF;
  logic [3:0] SEC_U;
  logic [2:0] SEC_T;
  logic [3:0] MIN_U;

  crono_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .BTN_SS(BTN_SS), .BTN_CLR(BTN_CLR), .BTN_LAP(BTN_LAP),
    .UNI_INC(UNI_INC), .DEZ_INC(DEZ_INC), .MIN_INC(MIN_INC), .DIG_CLR(DIG_CLR),
    .DISP_HOLD(DISP_HOLD), .RUNNING(RUNNING), .OVF(OVF),
    .SEC_U(SEC_U), .SEC_T(SEC_T), .MIN_U(MIN_U)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: elapsed seconds as one integer, a per-second cycle phase and a mode.
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;
  int   m_mode, m_secs, m_phase;
  logic m_hold, m_uni, m_dez, m_min, m_ovf, m_clr;
  logic [2:0] h_ss, h_clr, h_lap;   // [k] = button level sampled k+1 edges ago

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_secs = 0; m_phase = 0; m_hold = 0;
    m_uni = 0; m_dez = 0; m_min = 0; m_ovf = 0; m_clr = 0;
    h_ss = '0; h_clr = '0; h_lap = '0;
  endtask

  task automatic model_step(input logic ss, input logic clr, input logic lap);
    logic e_ss, e_clr, e_lap;
    // A press acts on the edge three edges after it is first sampled.
    e_ss  = h_ss[1]  & ~h_ss[2];
    e_clr = h_clr[1] & ~h_clr[2];
    e_lap = h_lap[1] & ~h_lap[2];
    h_ss  = {h_ss[1:0], ss};
    h_clr = {h_clr[1:0], clr};
    h_lap = {h_lap[1:0], lap};
    m_uni = 0; m_dez = 0; m_min = 0; m_ovf = 0; m_clr = 0;
    if (m_mode == M_RUN || m_mode == M_LAP) begin
      m_phase = m_phase + 1;
      if (m_phase == DIV) begin
        m_phase = 0;
        m_secs  = (m_secs + 1) % 600;
        m_uni   = 1;
        m_dez   = (m_secs % 10) == 0;
        m_min   = (m_secs % 60) == 0;
        m_ovf   = m_secs == 0;
      end
    end
    case (m_mode)
      M_IDLE: begin
        if (e_clr) begin m_clr = 1; m_secs = 0; end
        else if (e_ss) begin m_mode = M_RUN; m_phase = 0; end
      end
      M_RUN: begin
        if (e_ss) m_mode = M_PAUSE;
        else if (e_lap) begin m_mode = M_LAP; m_hold = 1; end
      end
      M_LAP: begin
        if (e_ss) m_mode = M_PAUSE;
        else if (e_lap) begin m_mode = M_RUN; m_hold = 0; end
      end
      default: begin
        if (e_clr) begin m_mode = M_IDLE; m_clr = 1; m_secs = 0; m_phase = 0; m_hold = 0; end
        else if (e_ss) begin m_mode = M_RUN; m_hold = 0; end
        else if (e_lap) m_hold = 0;
      end
    endcase
  endtask

  function automatic logic [31:0] dut_vec();
    return {14'd0, UNI_INC, DEZ_INC, MIN_INC, DIG_CLR, OVF, DISP_HOLD, RUNNING, SEC_U, SEC_T, MIN_U};
  endfunction

  function automatic logic [31:0] exp_vec();
    logic run;
    run = (m_mode == M_RUN) || (m_mode == M_LAP);
    return {14'd0, m_uni, m_dez, m_min, m_clr, m_ovf, m_hold, run,
            4'(m_secs % 10), 3'((m_secs / 10) % 6), 4'(m_secs / 60)};
  endfunction

  task automatic tick_cyc();
    @(posedge CLK);
    if (!RST_N) model_reset();
    else model_step(BTN_SS, BTN_CLR, BTN_LAP);
    @(negedge CLK);
    chk("model", dut_vec(), exp_vec());
  endtask

  task automatic press(input logic ss, input logic clr, input logic lap);
    BTN_SS = ss; BTN_CLR = clr; BTN_LAP = lap;
    tick_cyc();
    BTN_SS = 0; BTN_CLR = 0; BTN_LAP = 0;
    tick_cyc();
    tick_cyc();
  endtask

  task automatic wait_uni(output int n);
    n = 0;
    do begin
      tick_cyc();
      n++;
    end while (!UNI_INC && n < 40);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST_N = 0; BTN_SS = 0; BTN_CLR = 0; BTN_LAP = 0;
    tick_cyc();
    tick_cyc();
    RST_N = 1;
  endtask

  typedef struct {
    logic       ss, clr, lap;
    int         cycles;
    logic       exp_run, exp_hold;
    logic [3:0] exp_su;
    logic [2:0] exp_st;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int n, cnt;
    logic r_ss, r_clr, r_lap;

    vecs[0] = '{1, 0, 0,  3, 1, 0, 4'd0, 3'd0};
    vecs[1] = '{0, 0, 0, 25, 1, 0, 4'd2, 3'd0};
    vecs[2] = '{0, 0, 1,  3, 1, 1, 4'd2, 3'd0};
    vecs[3] = '{1, 0, 0,  3, 0, 1, 4'd3, 3'd0};
    vecs[4] = '{0, 0, 1,  3, 0, 0, 4'd3, 3'd0};
    vecs[5] = '{1, 0, 0, 20, 1, 0, 4'd4, 3'd0};
    vecs[6] = '{0, 1, 0,  3, 1, 0, 4'd5, 3'd0};
    vecs[7] = '{1, 0, 0,  3, 0, 0, 4'd5, 3'd0};
    vecs[8] = '{1, 1, 0,  3, 0, 0, 4'd0, 3'd0};
    vecs[9] = '{1, 0, 1,  3, 1, 0, 4'd0, 3'd0};

    model_reset();
    do_reset();
    chk("reset_outputs", dut_vec(), 32'd0);

    // Start: RUNNING three edges after the press, ticks every DIV cycles.
    press(1, 0, 0);
    chk("run_latency", {31'd0, RUNNING}, 32'd1);
    for (int k = 1; k <= 3; k++) begin
      wait_uni(n);
      chk("tick_period", n, 10);
      chk("sec_u_step", {28'd0, SEC_U}, k);
    end

    // Tenth tick carries into the tens digit.
    for (int k = 0; k < 7; k++) wait_uni(n);
    chk("dez_carry", {30'd0, UNI_INC, DEZ_INC}, 32'h3);
    chk("dez_digits", {25'd0, SEC_U, SEC_T}, {25'd0, 4'd0, 3'd1});

    // Run to 9:59 and wrap.
    for (int k = 0; k < 589; k++) wait_uni(n);
    chk("at_959", {21'd0, MIN_U, SEC_T, SEC_U}, {21'd0, 4'd9, 3'd5, 4'd9});
    wait_uni(n);
    chk("wrap_strobes", {28'd0, UNI_INC, DEZ_INC, MIN_INC, OVF}, 32'hF);
    chk("wrap_digits", {21'd0, MIN_U, SEC_T, SEC_U}, 32'd0);

    // Pause with the prescaler at 4, stay paused 50 cycles, resume.
    tick_cyc();
    press(1, 0, 0);
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      tick_cyc();
      cnt += int'(UNI_INC | DEZ_INC | MIN_INC | OVF);
    end
    chk("pause_no_strobes", cnt, 0);
    press(1, 0, 0);
    wait_uni(n);
    chk("resume_latency", n, 6);

    // CLR ignored while running; CLR after stop clears once and idles.
    press(0, 1, 0);
    chk("clr_ignored", {27'd0, RUNNING, SEC_U}, {27'd0, 1'b1, 4'd1});
    press(1, 0, 0);
    BTN_CLR = 1;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick_cyc();
      BTN_CLR = 0;
      cnt += int'(DIG_CLR);
    end
    chk("dig_clr_count", cnt, 1);
    chk("clr_state", {20'd0, RUNNING, DISP_HOLD, MIN_U, SEC_T, SEC_U}, 32'd0);

    // Lap view freezes the display while counting continues.
    press(1, 0, 0);
    press(0, 0, 1);
    chk("lap_hold", {31'd0, DISP_HOLD}, 32'd1);
    wait_uni(n);
    chk("lap_tick", n, 7);
    chk("lap_hold_tick", {30'd0, DISP_HOLD, UNI_INC}, 32'h3);
    press(1, 0, 0);
    chk("lap_stop", {30'd0, RUNNING, DISP_HOLD}, 32'h1);
    press(1, 1, 0);
    chk("clr_beats_ss", {20'd0, RUNNING, DISP_HOLD, MIN_U, SEC_T, SEC_U}, 32'd0);

    // Asynchronous reset in the middle of counting.
    press(1, 0, 0);
    for (int k = 0; k < 25; k++) tick_cyc();
    RST_N = 0;
    #1;
    chk("async_reset", dut_vec(), 32'd0);
    tick_cyc();
    tick_cyc();
    RST_N = 1;

    // Table of button sequences from a fresh reset.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      BTN_SS = vecs[i].ss; BTN_CLR = vecs[i].clr; BTN_LAP = vecs[i].lap;
      tick_cyc();
      BTN_SS = 0; BTN_CLR = 0; BTN_LAP = 0;
      for (int k = 1; k < vecs[i].cycles; k++) tick_cyc();
      chk($sformatf("vec%0d", i), {20'd0, RUNNING, DISP_HOLD, SEC_U, SEC_T, 3'd0},
          {20'd0, vecs[i].exp_run, vecs[i].exp_hold, vecs[i].exp_su, vecs[i].exp_st, 3'd0});
    end

    // Random button activity against the reference model.
    do_reset();
    r_ss = 0; r_clr = 0; r_lap = 0;
    for (int i = 0; i < 3000; i++) begin
      r_ss  = r_ss  ? ($urandom_range(2) != 0) : ($urandom_range(24) == 0);
      r_clr = r_clr ? ($urandom_range(2) != 0) : ($urandom_range(40) == 0);
      r_lap = r_lap ? ($urandom_range(2) != 0) : ($urandom_range(30) == 0);
      BTN_SS = r_ss; BTN_CLR = r_clr; BTN_LAP = r_lap;
      if (i == 1500) RST_N = 0;
      if (i == 1503) RST_N = 1;
      tick_cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
